// File: rtl/oled_spi_monitor.sv
// -----------------------------------------------------------------------------
// oled_spi_monitor
//
// Receive-side model of the Pmod OLED (SSD1306, 128x32) SPI link. Observes the
// CS/MOSI/SCK/data_command_cntr wires, rebuilds each byte, runs a small
// command decoder and keeps a shadow 4096-bit frame plus contrast and
// display-on state, so a tester can compare the reconstructed frame with the
// one it drove.
//
// Optional feature macro: OLED_SPI_MONITOR_ERRCNT_EN
//   When defined, adds output err_cnt[7:0]: a saturating count of
//   (a) CS rising with a partial byte pending and
//   (b) data bytes that arrive while a command argument is expected.
//
// Parameters
//   SYNC_STAGES   flip-flop depth of the input synchronisers (clamped to >= 2)
//   CONTRAST_RST  contrast value after reset
//
// Ports
//   clk                system clock
//   n_rst              asynchronous active-low reset
//   CS                 SPI chip select, active low
//   MOSI               SPI data, MSB first
//   SCK                SPI clock, sampled on its rising edge (f_SCK <= f_clk/4)
//   data_command_cntr  1 = data byte, 0 = command byte (taken with the 8th bit)
//   bitmap             shadow frame, pixel (r,c) at index 4095-(128*r+c)
//   contrast           last argument of command 0x81
//   display_on         1 after 0xAF, 0 after 0xAE
//   byte_valid         one-clk pulse per completed byte
//   byte_data          last completed byte
//   byte_is_data       data_command_cntr captured with byte_data
//   frame_done         one-clk pulse when the horizontal write pointer wraps
//   err_cnt            (optional) protocol error count, saturating at 255
//   dbg_state_o        command decoder state (0 IDLE, 1 ARG1, 2 ARG2)
//
// Handshake: byte_valid is a strobe with no back-pressure; byte_data and
// byte_is_data change only in the cycle byte_valid is high and hold until the
// next completed byte. All bitmap/pointer/register side effects of a byte
// become visible in that same cycle.
// -----------------------------------------------------------------------------
module oled_spi_monitor #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  CONTRAST_RST = 8'h7F
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          CS,
  input  logic          MOSI,
  input  logic          SCK,
  input  logic          data_command_cntr,
  output logic [4095:0] bitmap,
  output logic [7:0]    contrast,
  output logic          display_on,
  output logic          byte_valid,
  output logic [7:0]    byte_data,
  output logic          byte_is_data,
  output logic          frame_done,
`ifdef OLED_SPI_MONITOR_ERRCNT_EN
  output logic [7:0]    err_cnt,
`endif
  output logic [1:0]    dbg_state_o
);

  localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } state_e;

  localparam logic [1:0] MODE_PAGE = 2'd2;

  // ---------------------------------------------------------------------------
  // Input synchronisers. CS resets high (deselected) so a reset never looks
  // like the start of a transfer.
  // ---------------------------------------------------------------------------
  logic [SS-1:0] cs_sync_q, mosi_sync_q, sck_sync_q, dc_sync_q;
  logic          sck_prev_q;
  logic          cs_s, mosi_s, sck_s, dc_s, sck_rise;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_sync_q  <= '0;
      dc_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SS-2:0], CS};
      mosi_sync_q <= {mosi_sync_q[SS-2:0], MOSI};
      sck_sync_q  <= {sck_sync_q[SS-2:0], SCK};
      dc_sync_q   <= {dc_sync_q[SS-2:0], data_command_cntr};
      sck_prev_q  <= sck_sync_q[SS-1];
    end
  end

  assign cs_s     = cs_sync_q[SS-1];
  assign mosi_s   = mosi_sync_q[SS-1];
  assign sck_s    = sck_sync_q[SS-1];
  assign dc_s     = dc_sync_q[SS-1];
  assign sck_rise = sck_s & ~sck_prev_q;

  // ---------------------------------------------------------------------------
  // Bit shifter
  // ---------------------------------------------------------------------------
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rx_byte;
  logic       byte_done;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    rx_byte   = {shift_q, mosi_s};
    if (cs_s) begin
      // Deselect drops any partial byte.
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      shift_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_done = (bit_cnt_q == 3'd7);
    end
  end

  // ---------------------------------------------------------------------------
  // Command decoder / frame writer state
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [6:0]      col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [1:0]      page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      contrast_q, contrast_d;
  logic            disp_q, disp_d;
  logic [4095:0]   bitmap_q, bitmap_d;
  logic            bv_q, bv_d;
  logic [7:0]      bdata_q, bdata_d;
  logic            bis_q, bis_d;
  logic            fd_q, fd_d;
  logic            col_wrap, page_wrap;

  // Degenerate windows (start > end) still wrap at the physical edge.
  assign col_wrap  = (col_q == col_end_q) || (col_q == 7'd127);
  assign page_wrap = (page_q == page_end_q) || (page_q == 2'd3);

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    mode_d       = mode_q;
    contrast_d   = contrast_q;
    disp_d       = disp_q;
    bitmap_d     = bitmap_q;
    bv_d         = byte_done;
    bdata_d      = bdata_q;
    bis_d        = bis_q;
    fd_d         = 1'b0;

    if (byte_done) begin
      bdata_d = rx_byte;
      bis_d   = dc_s;

      unique case (state_q)
        ST_IDLE: begin
          if (dc_s) begin
            // Bit k lands on row 8*page+k; 4095-x equals ~x on 12 bits.
            for (int k = 0; k < 8; k++) begin
              bitmap_d[~{page_q, 3'(k), col_q}] = rx_byte[k];
            end
            if (mode_q == MODE_PAGE) begin
              col_d = col_q + 7'd1;  // 127 wraps to 0 naturally
            end else if (col_wrap) begin
              col_d = col_start_q;
              if (page_wrap) begin
                page_d = page_start_q;
                fd_d   = 1'b1;
              end else begin
                page_d = page_q + 2'd1;
              end
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (rx_byte)
              8'hAE: disp_d = 1'b0;
              8'hAF: disp_d = 1'b1;
              8'h81, 8'h20, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB,
              8'h21, 8'h22: begin
                cmd_d   = rx_byte;
                state_d = ST_ARG1;
              end
              default: begin
                if (rx_byte[7:4] == 4'h0) begin
                  col_d = {col_q[6:4], rx_byte[3:0]};
                end else if (rx_byte[7:3] == 5'b00010) begin
                  col_d = {rx_byte[2:0], col_q[3:0]};
                end else if (rx_byte[7:3] == 5'b10110) begin
                  page_d = rx_byte[1:0];
                end
              end
            endcase
          end
        end

        ST_ARG1: begin
          state_d = ST_IDLE;
          case (cmd_q)
            8'h81: contrast_d = rx_byte;
            8'h20: mode_d = rx_byte[1:0];
            8'h21: begin
              col_start_d = rx_byte[6:0];
              col_d       = rx_byte[6:0];
              state_d     = ST_ARG2;
            end
            8'h22: begin
              page_start_d = rx_byte[1:0];
              page_d       = rx_byte[1:0];
              state_d      = ST_ARG2;
            end
            default: ;
          endcase
        end

        ST_ARG2: begin
          state_d = ST_IDLE;
          if (cmd_q == 8'h21) begin
            col_end_d = rx_byte[6:0];
          end else begin
            page_end_d = rx_byte[1:0];
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      state_q      <= ST_IDLE;
      cmd_q        <= 8'h00;
      col_q        <= 7'd0;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'd127;
      page_q       <= 2'd0;
      page_start_q <= 2'd0;
      page_end_q   <= 2'd3;
      mode_q       <= MODE_PAGE;
      contrast_q   <= CONTRAST_RST;
      disp_q       <= 1'b0;
      bitmap_q     <= '0;
      bv_q         <= 1'b0;
      bdata_q      <= 8'h00;
      bis_q        <= 1'b0;
      fd_q         <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      mode_q       <= mode_d;
      contrast_q   <= contrast_d;
      disp_q       <= disp_d;
      bitmap_q     <= bitmap_d;
      bv_q         <= bv_d;
      bdata_q      <= bdata_d;
      bis_q        <= bis_d;
      fd_q         <= fd_d;
    end
  end

`ifdef OLED_SPI_MONITOR_ERRCNT_EN
  // ---------------------------------------------------------------------------
  // Protocol error counter
  // ---------------------------------------------------------------------------
  logic       cs_prev_q;
  logic [7:0] err_q, err_d;
  logic       err_inc;

  // bit_cnt_q still holds the partial count in the cycle CS is seen rising.
  assign err_inc = (cs_s && !cs_prev_q && (bit_cnt_q != 3'd0)) ||
                   (byte_done && dc_s && (state_q != ST_IDLE));

  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cs_prev_q <= 1'b1;
      err_q     <= 8'h00;
    end else begin
      cs_prev_q <= cs_s;
      err_q     <= err_d;
    end
  end

  assign err_cnt = err_q;
`endif

  assign bitmap       = bitmap_q;
  assign contrast     = contrast_q;
  assign display_on   = disp_q;
  assign byte_valid   = bv_q;
  assign byte_data    = bdata_q;
  assign byte_is_data = bis_q;
  assign frame_done   = fd_q;
  assign dbg_state_o  = state_q;

endmodule
